// File: rtl/req_ack_if.sv
// Request/acknowledge handshake bundle between initiator and responder.
interface req_ack_if #(
  parameter int unsigned CNT_W = 2
);
  logic             req;
  logic             ack;
  logic             busy;
  logic             viol_held;
  logic             viol_early;
  logic [CNT_W-1:0] ack_count;

  modport master (output req, input ack, busy, viol_held, viol_early, ack_count);
  modport slave  (input req, output ack, busy, viol_held, viol_early, ack_count);
endinterface

// File: rtl/req_ack_responder.sv
// Responder for the single-cycle req/ack handshake: fixed-latency ack,
// request-spacing enforcement with violation pulses, wrapping ack counter.
module req_ack_responder #(
  parameter int unsigned ACK_LATENCY = 4,
  parameter int unsigned MIN_REQ_GAP = 8,
  parameter int unsigned CNT_W       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  req_ack_if.slave   bus
);

  localparam int unsigned TW = $clog2(MIN_REQ_GAP + 1);
  localparam logic [TW-1:0] ONE_T = TW'(1);
  localparam logic [TW-1:0] LAT_T = TW'(ACK_LATENCY);
  localparam logic [TW-1:0] GAP_T = TW'(MIN_REQ_GAP);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t           state_q, state_nxt;
  logic [TW-1:0]    timer_q, timer_nxt;
  logic [TW-1:0]    timer_inc;
  logic             ack_q, ack_nxt;
  logic             busy_q, busy_nxt;
  logic             held_q, held_nxt;
  logic             early_q, early_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             req_q;
  logic             accept;

  assign timer_inc = timer_q + ONE_T;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      held_q  <= 1'b0;
      early_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
      ack_q   <= ack_nxt;
      busy_q  <= busy_nxt;
      held_q  <= held_nxt;
      early_q <= early_nxt;
      cnt_q   <= cnt_nxt;
      req_q   <= bus.req;
    end
  end

  // Next-state: accept in IDLE or on the gap-expiry edge; otherwise a req while busy is dropped.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    busy_nxt  = busy_q;
    ack_nxt   = 1'b0;
    held_nxt  = 1'b0;
    early_nxt = 1'b0;
    cnt_nxt   = cnt_q;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req) accept = 1'b1;
      end
      WAIT: begin
        timer_nxt = timer_inc;
        if (timer_inc == LAT_T) begin
          ack_nxt   = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (timer_q == GAP_T) begin
          if (bus.req) begin
            accept = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            timer_nxt = '0;
          end
        end else begin
          timer_nxt = timer_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        timer_nxt = '0;
      end
    endcase

    if (accept) begin
      timer_nxt = ONE_T;
      busy_nxt  = 1'b1;
      if (ACK_LATENCY == 1) begin
        ack_nxt   = 1'b1;
        state_nxt = GAP;
      end else begin
        state_nxt = WAIT;
      end
    end else if (bus.req && state_q != IDLE) begin
      held_nxt  = req_q;
      early_nxt = !req_q;
    end

    if (ack_nxt) cnt_nxt = cnt_q + CNT_W'(1);
  end

  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
  assign bus.viol_held  = held_q;
  assign bus.viol_early = early_q;
  assign bus.ack_count  = cnt_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Randomized and directed check of req_ack_responder against a cycle-indexed
// model built from accept times (last accepted req, ack/busy windows).
module tb_req_ack_responder;

  localparam int L     = 4;
  localparam int G     = 8;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  req_ack_if #(.CNT_W(CNT_W)) bus ();

  req_ack_responder #(.ACK_LATENCY(L), .MIN_REQ_GAP(G), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int e;
  bit have_acc;
  int last_acc;
  int m_cnt;
  bit m_prev;
  bit x_ack, x_busy, x_held, x_early;

  // per-test logs, index = spec cycle = edge + 1
  bit ack_log  [0:63];
  bit busy_log [0:63];
  bit held_log [0:63];
  bit early_log[0:63];
  int cnt_log  [0:63];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", name, e, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit rn);
    bit inwin;
    x_held  = 1'b0;
    x_early = 1'b0;
    if (!rn) begin
      have_acc = 1'b0;
      m_cnt    = 0;
      m_prev   = 1'b0;
      x_ack    = 1'b0;
      x_busy   = 1'b0;
    end else begin
      inwin = have_acc && (e - last_acc) < G;
      if (r && !inwin) begin
        have_acc = 1'b1;
        last_acc = e;
      end else if (r) begin
        x_held  = m_prev;
        x_early = !m_prev;
      end
      m_prev = r;
      x_ack  = have_acc && (e == last_acc + L - 1);
      if (x_ack) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      x_busy = have_acc && (e - last_acc) < G;
    end
  endtask

  task automatic run_cycle(input bit r, input bit rn);
    @(negedge clk);
    bus.req = r;
    rst_n   = rn;
    @(posedge clk);
    #1;
    e = e + 1;
    model_step(r, rn);
    chk("ack",        int'(bus.ack),        int'(x_ack));
    chk("busy",       int'(bus.busy),       int'(x_busy));
    chk("viol_held",  int'(bus.viol_held),  int'(x_held));
    chk("viol_early", int'(bus.viol_early), int'(x_early));
    chk("ack_count",  int'(bus.ack_count),  m_cnt);
    if (e >= 0 && e + 1 < 64) begin
      ack_log[e+1]   = bus.ack;
      busy_log[e+1]  = bus.busy;
      held_log[e+1]  = bus.viol_held;
      early_log[e+1] = bus.viol_early;
      cnt_log[e+1]   = int'(bus.ack_count);
    end
  endtask

  task automatic begin_test();
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      ack_log[i] = 0; busy_log[i] = 0; held_log[i] = 0;
      early_log[i] = 0; cnt_log[i] = 0;
    end
    e = -1;
  endtask

  task automatic run_directed(input logic [63:0] reqm, input logic [63:0] rstm, input int n);
    begin_test();
    for (int i = 0; i < n; i++) run_cycle(reqm[i], !rstm[i]);
  endtask

  initial begin
    logic [63:0] m;
    bit r;
    int p;
    bus.req = 1'b0;
    e = 0;
    have_acc = 0; last_acc = 0; m_cnt = 0; m_prev = 0;

    // reset state, checked while rst_n is still low
    #1;
    chk("rst_ack",   int'(bus.ack),       0);
    chk("rst_busy",  int'(bus.busy),      0);
    chk("rst_count", int'(bus.ack_count), 0);

    // 1: single req at 2
    run_directed(64'(1) << 2, 64'd0, 20);
    chk("t1_ack5",   int'(ack_log[5]),  0);
    chk("t1_ack6",   int'(ack_log[6]),  1);
    chk("t1_ack7",   int'(ack_log[7]),  0);
    chk("t1_cnt6",   cnt_log[6],        1);
    chk("t1_cnt15",  cnt_log[15],       1);
    chk("t1_busy2",  int'(busy_log[2]), 0);
    chk("t1_busy3",  int'(busy_log[3]), 1);
    chk("t1_busy10", int'(busy_log[10]),1);
    chk("t1_busy11", int'(busy_log[11]),0);

    // 2: reqs at 2 and 10 (boundary accept)
    run_directed((64'(1) << 2) | (64'(1) << 10), 64'd0, 24);
    chk("t2_ack6",   int'(ack_log[6]),   1);
    chk("t2_ack14",  int'(ack_log[14]),  1);
    chk("t2_early11",int'(early_log[11]),0);
    chk("t2_held11", int'(held_log[11]), 0);
    chk("t2_cnt20",  cnt_log[20],        2);
    chk("t2_busy11", int'(busy_log[11]), 1);

    // 3: early req at 5 dropped
    run_directed((64'(1) << 2) | (64'(1) << 5), 64'd0, 20);
    chk("t3_ack6",   int'(ack_log[6]),   1);
    chk("t3_early6", int'(early_log[6]), 1);
    chk("t3_early7", int'(early_log[7]), 0);
    chk("t3_ack9",   int'(ack_log[9]),   0);
    chk("t3_cnt19",  cnt_log[19],        1);

    // 4: req held over cycles 2-3
    run_directed((64'(1) << 2) | (64'(1) << 3), 64'd0, 20);
    chk("t4_held4",  int'(held_log[4]),  1);
    chk("t4_early4", int'(early_log[4]), 0);
    chk("t4_held5",  int'(held_log[5]),  0);
    chk("t4_ack6",   int'(ack_log[6]),   1);
    chk("t4_cnt19",  cnt_log[19],        1);

    // 5: reset cancels the pending ack
    run_directed((64'(1) << 2) | (64'(1) << 8), (64'(1) << 4) | (64'(1) << 5), 20);
    chk("t5_ack6",   int'(ack_log[6]),  0);
    chk("t5_busy6",  int'(busy_log[6]), 0);
    chk("t5_cnt7",   cnt_log[7],        0);
    chk("t5_ack12",  int'(ack_log[12]), 1);
    chk("t5_cnt12",  cnt_log[12],       1);

    // 6: counter wrap
    m = (64'(1) << 2) | (64'(1) << 10) | (64'(1) << 18) | (64'(1) << 26) | (64'(1) << 34);
    run_directed(m, 64'd0, 42);
    chk("t6_cnt5",  cnt_log[5],  0);
    chk("t6_cnt6",  cnt_log[6],  1);
    chk("t6_cnt14", cnt_log[14], 2);
    chk("t6_cnt22", cnt_log[22], 3);
    chk("t6_cnt30", cnt_log[30], 0);
    chk("t6_cnt38", cnt_log[38], 1);

    // random: sparse pulses, held bursts, occasional reset
    begin_test();
    r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      p = int'($urandom_range(0, 99));
      if (r && p < 40) r = 1'b1;
      else             r = (p < 12);
      run_cycle(r, $urandom_range(0, 299) != 0);
    end
    run_cycle(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
